cfg_req_bridge: RTL and testbench

CFG_REQ_BRIDGE -- requirements
Module: cfg_req_bridge

---
 rtl/cfg_req_bridge.sv | 241 ++++++++++++++++++++++++
 tb/tb_cfg_req_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_req_bridge.sv
// Host-to-register-block request bridge.
// It accepts one host request at a time, issues it as a cfg_req, waits for the
// matching cfg_ack and then returns a registered response to the host.
// Optional build macro CFG_REQ_BRIDGE_TIMEOUT_EN: when defined, a WAIT that
// lasts TIMEOUT_CYCLES cycles without a completion ends with status TIMEOUT.

package cfg_req_bridge_pkg;

    typedef enum logic [3:0] {
        CFG_MRD   = 4'h0,
        CFG_MWR   = 4'h1,
        CFG_IORD  = 4'h2,
        CFG_IOWR  = 4'h3,
        CFG_CFGRD = 4'h4,
        CFG_CFGWR = 4'h5,
        CFG_CRRD  = 4'h6,
        CFG_CRWR  = 4'h7
    } cfg_opcode_t;

    typedef logic [47:0] cfg_addr_t;

    // opcode is plain logic so that undefined opcodes can still be captured
    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        cfg_addr_t   addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic [7:0]  sai;
        logic [7:0]  fid;
        logic [2:0]  bar;
    } cfg_req_64bit_t;

    typedef struct packed {
        logic        read_valid;
        logic        read_miss;
        logic        write_valid;
        logic        write_miss;
        logic        sai_successfull;
        logic [63:0] data;
    } cfg_ack_64bit_t;

    localparam logic [1:0] RSP_OK       = 2'b00;
    localparam logic [1:0] RSP_MISS     = 2'b01;
    localparam logic [1:0] RSP_SAI_FAIL = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT  = 2'b11;

endpackage

module cfg_req_bridge
    import cfg_req_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_req_valid,
    output logic          host_req_ready,
    input  logic [3:0]    host_req_opcode,
    input  logic [47:0]   host_req_addr,
    input  logic [7:0]    host_req_be,
    input  logic [63:0]   host_req_data,
    input  logic [7:0]    host_req_sai,
    input  logic [7:0]    host_req_fid,
    input  logic [2:0]    host_req_bar,
    output logic [143:0]  cfg_req,
    input  logic [68:0]   cfg_ack,
    output logic          host_rsp_valid,
    input  logic          host_rsp_ready,
    output logic [63:0]   host_rsp_data,
    output logic [1:0]    host_rsp_status
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    cfg_req_64bit_t      req_q;
    cfg_ack_64bit_t      ack;

    logic                req_ready_q;
    logic                req_ready_d;
    logic                cfg_valid_d;
    logic                rsp_valid_q;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [DATA_W-1:0]   rsp_data_d;
    logic [1:0]          rsp_status_q;
    logic [1:0]          rsp_status_d;

    logic                accept_c;
    logic                is_read_c;
    logic                done_c;
    logic                miss_c;
    logic                timeout_c;

    assign ack = cfg_ack_64bit_t'(cfg_ack);

    // Handshake and completion decode for the captured request class
    assign accept_c  = (state_q == ST_IDLE) && host_req_valid;
    assign is_read_c = ~req_q.opcode[0];
    assign miss_c    = is_read_c ? ack.read_miss : ack.write_miss;
    assign done_c    = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) &&
                       (is_read_c ? (ack.read_valid  | ack.read_miss)
                                  : (ack.write_valid | ack.write_miss));

`ifdef CFG_REQ_BRIDGE_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt_q;

    // WAIT-cycle counter, cleared whenever a request is about to be issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_d == ST_ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    // Fires in the last permitted WAIT cycle; a same-cycle completion wins
    assign timeout_c = (state_q == ST_WAIT) &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // The limit only matters when the timeout feature is built in
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = |CNT_W'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    // State register plus registered host-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= RSP_OK;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = host_req_opcode[3] ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = done_c ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (done_c || timeout_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (host_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values; response payload only changes when a response is formed
    always_comb begin
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_valid_d  = (state_d == ST_RESP);
        req_ready_d  = (state_d == ST_IDLE);
        cfg_valid_d  = (state_d == ST_ISSUE);
        case (state_q)
            ST_IDLE: begin
                if (accept_c && host_req_opcode[3]) begin
                    rsp_status_d = RSP_MISS;
                    rsp_data_d   = '0;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (done_c) begin
                    if (miss_c) begin
                        rsp_status_d = RSP_MISS;
                        rsp_data_d   = '0;
                    end else if (!ack.sai_successfull) begin
                        rsp_status_d = RSP_SAI_FAIL;
                        rsp_data_d   = '0;
                    end else begin
                        rsp_status_d = RSP_OK;
                        rsp_data_d   = is_read_c ? ack.data : '0;
                    end
                end else if (timeout_c) begin
                    rsp_status_d = RSP_TIMEOUT;
                    rsp_data_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // Request capture on accept; valid is a single ISSUE-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q.valid <= cfg_valid_d;
            if (accept_c) begin
                req_q.opcode <= host_req_opcode;
                req_q.addr   <= host_req_addr;
                req_q.be     <= host_req_be;
                req_q.data   <= host_req_data;
                req_q.sai    <= host_req_sai;
                req_q.fid    <= host_req_fid;
                req_q.bar    <= host_req_bar;
            end
        end
    end

    assign host_req_ready  = req_ready_q;
    assign cfg_req         = req_q;
    assign host_rsp_valid  = rsp_valid_q;
    assign host_rsp_data   = rsp_data_q;
    assign host_rsp_status = rsp_status_q;

endmodule

// File: tb/tb_cfg_req_bridge.sv
// Directed testbench for cfg_req_bridge.
// Covers the default build and, when CFG_REQ_BRIDGE_TIMEOUT_EN is defined,
// the timeout path with TIMEOUT_CYCLES = 4.
module tb_cfg_req_bridge;
    import cfg_req_bridge_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_req_valid;
    logic          host_req_ready;
    logic [3:0]    host_req_opcode;
    logic [47:0]   host_req_addr;
    logic [7:0]    host_req_be;
    logic [63:0]   host_req_data;
    logic [7:0]    host_req_sai;
    logic [7:0]    host_req_fid;
    logic [2:0]    host_req_bar;
    logic [143:0]  cfg_req;
    logic [68:0]   cfg_ack;
    logic          host_rsp_valid;
    logic          host_rsp_ready;
    logic [63:0]   host_rsp_data;
    logic [1:0]    host_rsp_status;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;
    int p0;

    always #5 clk = ~clk;

    cfg_req_bridge #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_opcode (host_req_opcode),
        .host_req_addr   (host_req_addr),
        .host_req_be     (host_req_be),
        .host_req_data   (host_req_data),
        .host_req_sai    (host_req_sai),
        .host_req_fid    (host_req_fid),
        .host_req_bar    (host_req_bar),
        .cfg_req         (cfg_req),
        .cfg_ack         (cfg_ack),
        .host_rsp_valid  (host_rsp_valid),
        .host_rsp_ready  (host_rsp_ready),
        .host_rsp_data   (host_rsp_data),
        .host_rsp_status (host_rsp_status)
    );

    // Count cycles in which cfg_req.valid is high
    always @(negedge clk) begin
        if (cfg_req[143] === 1'b1) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] exp_req(input logic v, input logic [3:0] op,
                                             input logic [47:0] addr, input logic [7:0] be,
                                             input logic [63:0] data, input logic [7:0] sai,
                                             input logic [7:0] fid, input logic [2:0] bar);
        cfg_req_64bit_t e;
        e.valid  = v;
        e.opcode = op;
        e.addr   = addr;
        e.be     = be;
        e.data   = data;
        e.sai    = sai;
        e.fid    = fid;
        e.bar    = bar;
        return e;
    endfunction

    task automatic set_ack(input logic rv, input logic rm, input logic wv, input logic wm,
                           input logic sai_ok, input logic [63:0] data);
        cfg_ack_64bit_t a;
        a.read_valid      = rv;
        a.read_miss       = rm;
        a.write_valid     = wv;
        a.write_miss      = wm;
        a.sai_successfull = sai_ok;
        a.data            = data;
        cfg_ack = a;
    endtask

    // Present a request in IDLE and let it be accepted on the next edge
    task automatic drive_req(input string tag, input logic [3:0] op, input logic [47:0] addr,
                             input logic [7:0] be, input logic [63:0] data,
                             input logic [7:0] sai, input logic [7:0] fid, input logic [2:0] bar);
        host_req_opcode = op;
        host_req_addr   = addr;
        host_req_be     = be;
        host_req_data   = data;
        host_req_sai    = sai;
        host_req_fid    = fid;
        host_req_bar    = bar;
        host_req_valid  = 1'b1;
        chk({tag, "_req_ready"}, 64'(host_req_ready), 64'd1);
        tick();
        host_req_valid  = 1'b0;
    endtask

    // Accept the pending response and confirm return to IDLE
    task automatic finish_rsp(input string tag);
        host_rsp_ready = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
        chk({tag, "_idle_valid"}, 64'(host_rsp_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(host_req_ready), 64'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        host_req_valid  = 1'b0;
        host_req_opcode = '0;
        host_req_addr   = '0;
        host_req_be     = '0;
        host_req_data   = '0;
        host_req_sai    = '0;
        host_req_fid    = '0;
        host_req_bar    = '0;
        host_rsp_ready  = 1'b0;
        cfg_ack         = '0;

        // Reset values
        tick();
        tick();
        chk_req("rst_cfg_req", cfg_req, 144'd0);
        chk("rst_rsp_valid", 64'(host_rsp_valid), 64'd0);
        chk("rst_rsp_data", host_rsp_data, 64'd0);
        chk("rst_rsp_status", 64'(host_rsp_status), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_req_ready", 64'(host_req_ready), 64'd1);

        // CFGRD, read_valid two cycles after ISSUE
        drive_req("t1", CFG_CFGRD, 48'h10, 8'hFF, 64'h0, 8'h11, 8'h02, 3'd1);
        chk_req("t1_issue_req", cfg_req, exp_req(1'b1, 4'h4, 48'h10, 8'hFF, 64'h0, 8'h11, 8'h02, 3'd1));
        chk("t1_issue_ready", 64'(host_req_ready), 64'd0);
        tick();
        chk_req("t1_wait_req", cfg_req, exp_req(1'b0, 4'h4, 48'h10, 8'hFF, 64'h0, 8'h11, 8'h02, 3'd1));
        tick();
        chk("t1_wait_valid", 64'(host_rsp_valid), 64'd0);
        set_ack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF_01234567);
        tick();
        cfg_ack = '0;
        chk("t1_rsp_valid", 64'(host_rsp_valid), 64'd1);
        chk("t1_rsp_status", 64'(host_rsp_status), 64'd0);
        chk("t1_rsp_data", host_rsp_data, 64'hDEADBEEF_01234567);
        chk("t1_pulses", 64'(pulses), 64'd1);
        finish_rsp("t1");

        // MWR: read-class ack ignored, then write_miss; response held 10 cycles
        drive_req("t2", CFG_MWR, 48'h20, 8'h01, 64'h55, 8'h11, 8'h00, 3'd0);
        set_ack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1234);
        tick();
        chk("t2_other_class_ignored", 64'(host_rsp_valid), 64'd0);
        set_ack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1234);
        tick();
        set_ack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h9999);
        chk("t2_rsp_valid", 64'(host_rsp_valid), 64'd1);
        chk("t2_rsp_status", 64'(host_rsp_status), 64'd1);
        chk("t2_rsp_data", host_rsp_data, 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_valid", 64'(host_rsp_valid), 64'd1);
            chk("t2_hold_status", 64'(host_rsp_status), 64'd1);
            chk("t2_hold_data", host_rsp_data, 64'd0);
            chk("t2_hold_req_ready", 64'(host_req_ready), 64'd0);
        end
        cfg_ack = '0;
        finish_rsp("t2");

        // CRRD with SAI failure
        drive_req("t3", CFG_CRRD, 48'h40, 8'h0F, 64'h0, 8'h22, 8'h01, 3'd2);
        set_ack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hAAAA_BBBB);
        tick();
        cfg_ack = '0;
        chk("t3_rsp_valid", 64'(host_rsp_valid), 64'd1);
        chk("t3_rsp_status", 64'(host_rsp_status), 64'd2);
        chk("t3_rsp_data", host_rsp_data, 64'd0);
        finish_rsp("t3");

        // Undefined opcode 4'hA: straight to RESP with MISS, no issue pulse
        p0 = pulses;
        drive_req("t4", 4'hA, 48'h30, 8'h3C, 64'h77, 8'h05, 8'h06, 3'd7);
        chk("t4_rsp_valid", 64'(host_rsp_valid), 64'd1);
        chk("t4_rsp_status", 64'(host_rsp_status), 64'd1);
        chk("t4_rsp_data", host_rsp_data, 64'd0);
        chk_req("t4_cfg_req", cfg_req, exp_req(1'b0, 4'hA, 48'h30, 8'h3C, 64'h77, 8'h05, 8'h06, 3'd7));
        finish_rsp("t4");
        chk("t4_no_pulse", 64'(pulses), 64'(p0));

        // MRD with read_miss and SAI failure: miss has priority
        drive_req("t5", CFG_MRD, 48'h50, 8'hFF, 64'h0, 8'h01, 8'h01, 3'd0);
        set_ack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1111);
        tick();
        cfg_ack = '0;
        chk("t5_rsp_status", 64'(host_rsp_status), 64'd1);
        chk("t5_rsp_data", host_rsp_data, 64'd0);
        finish_rsp("t5");

        // Reset during WAIT abandons the request
        drive_req("t6", CFG_CFGWR, 48'h60, 8'hFF, 64'hCAFE, 8'h01, 8'h02, 3'd3);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_req("t6_rst_cfg_req", cfg_req, 144'd0);
        chk("t6_rst_rsp_valid", 64'(host_rsp_valid), 64'd0);
        #1;
        rst_n = 1'b1;
        set_ack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0);
        tick();
        chk("t6_post_valid", 64'(host_rsp_valid), 64'd0);
        chk("t6_post_ready", 64'(host_req_ready), 64'd1);
        tick();
        chk("t6_post_valid2", 64'(host_rsp_valid), 64'd0);
        cfg_ack = '0;

`ifdef CFG_REQ_BRIDGE_TIMEOUT_EN
        // No ack: TIMEOUT after four WAIT cycles, late ack ignored
        drive_req("t7", CFG_MRD, 48'h70, 8'hFF, 64'h0, 8'h01, 8'h00, 3'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("t7_wait4_valid", 64'(host_rsp_valid), 64'd0);
        tick();
        chk("t7_rsp_valid", 64'(host_rsp_valid), 64'd1);
        chk("t7_rsp_status", 64'(host_rsp_status), 64'd3);
        chk("t7_rsp_data", host_rsp_data, 64'd0);
        set_ack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hBEEF);
        tick();
        cfg_ack = '0;
        chk("t7_late_status", 64'(host_rsp_status), 64'd3);
        chk("t7_late_data", host_rsp_data, 64'd0);
        finish_rsp("t7");

        // Ack in the timeout cycle wins
        drive_req("t8", CFG_MRD, 48'h80, 8'hFF, 64'h0, 8'h01, 8'h00, 3'd0);
        for (int i = 0; i < 4; i++) tick();
        set_ack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
        tick();
        cfg_ack = '0;
        chk("t8_rsp_status", 64'(host_rsp_status), 64'd0);
        chk("t8_rsp_data", host_rsp_data, 64'h77);
        finish_rsp("t8");
`else
        // Without the timeout feature WAIT persists until completion
        drive_req("t7", CFG_MRD, 48'h70, 8'hFF, 64'h0, 8'h01, 8'h00, 3'd0);
        for (int i = 0; i < 300; i++) tick();
        chk("t7_long_wait_valid", 64'(host_rsp_valid), 64'd0);
        chk("t7_long_wait_ready", 64'(host_req_ready), 64'd0);
        set_ack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
        tick();
        cfg_ack = '0;
        chk("t7_rsp_status", 64'(host_rsp_status), 64'd0);
        chk("t7_rsp_data", host_rsp_data, 64'h77);
        finish_rsp("t7");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
